alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU in the single-cycle CPU. It accepts operation requests (operands plus 4-bit ALU control) from two clients, grants one at a time, and latches the operands into the ALU for a fixed number of cycles. It then captures the result and returns it with a requester ID over a single valid/ready response channel. It sits between the ALU and its clients, for example the main datapath and a branch/compare unit.

## Interface
- ALU_LAT, 1: cycles operands are held on the ALU before the result is captured; legal range 1..4.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req0_valid_i / req1_valid_i  in  1  request pending from requester 0 / 1.
- req0_ready_o / req1_ready_o  out  1  grant; a request is accepted in any cycle where valid and ready are both high.
- req0_src1_i / req1_src1_i  in  32  first operand.
- req0_src2_i / req1_src2_i  in  32  second operand.
- req0_ctrl_i / req1_ctrl_i  in  4  ALU control code; passed through unmodified.
- alu_src1_o, alu_src2_o  out  32  operands driven to the ALU.
- alu_ctrl_o  out  4  control driven to the ALU.
- alu_result_i  in  32  ALU result.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  1  requester that owns the response (0 or 1).
- rsp_result_o  out  32  captured ALU result.
- rsp_zero_o  out  1  high when the captured result equals 32'h0; computed locally.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - At most one reqN_ready_o is high, the one for the granted requester.
  - Grant is combinational from the valid inputs and the arbitration policy.
  - ready is low when neither requester is valid.
  - On handshake: src1, src2, ctrl and id are latched, lat_cnt is loaded with 0, and the FSM moves to EXEC.
- EXEC:
  - alu_*_o drive the latched registers.
  - lat_cnt increments each cycle.
  - When lat_cnt == ALU_LAT-1: alu_result_i is captured into rsp_result_o, rsp_zero_o is computed from it, and the FSM moves to RESP.
- RESP:
  - rsp_valid_o is high.
  - rsp_id_o, rsp_result_o and rsp_zero_o stay stable until rsp_valid_o && rsp_ready_i, then the FSM moves to IDLE.
- Both reqN_ready_o are low in EXEC and RESP. Only one operation is outstanding.
- alu_*_o keep their last latched values in IDLE and RESP; they do not return to 0.
- Control codes the ALU does not decode are forwarded unchanged; the ALU's result (0) is returned.
- last_id register: records the id of each accepted request; resets to 1, so requester 0 wins the first contested grant.

## Timing
- Reset values:
  - state = IDLE, lat_cnt = 0, last_id = 1.
  - alu_src1_o = alu_src2_o = 32'h0, alu_ctrl_o = 4'h0.
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_result_o = 32'h0, rsp_zero_o = 0.
  - req0_ready_o and req1_ready_o follow IDLE combinationally: ready only if valid.
- Cycle timeline:
  - Handshake in cycle T.
  - alu_*_o show the new operands from T+1.
  - Result is captured at the edge ending cycle T+ALU_LAT.
  - rsp_valid_o is high from T+ALU_LAT+1.
- If the response handshake occurs in cycle R, the next request can be accepted in cycle R+1.
- Minimum spacing between accepts is ALU_LAT+2 cycles.
- Requester operands may change the cycle after acceptance; the block does not depend on them afterwards.
- Reset asserted in any state, including mid-EXEC or RESP with rsp_ready_i low, aborts the operation with no response and restores all reset values immediately.
- A request withdrawn (valid dropped) before handshake is not an error; nothing is latched.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, the one whose id differs from last_id is granted. A lone valid requester is always granted.
- ALU_ARB_RR_EN undefined: fixed priority. Requester 0 always wins a contested grant. last_id is still maintained but ignored for arbitration.

## Test plan
- ALU_LAT=1, req0 only: src1=5, src2=7, ctrl=4'b0010 -> accept at T, rsp_valid at T+2 with rsp_id=0, result=32'd12, zero=0.
- req1 only: src1=9, src2=9, ctrl=4'b0110 -> result=0, zero=1, rsp_id=1. Then ctrl=4'b1111 -> result=0, zero=1.
- With ALU_ARB_RR_EN, both requesters continuously valid for 4 operations -> ids 0,1,0,1. Without the macro -> ids 0,0,0,0.
- ALU_LAT=3, req0: src1=32'hFFFF0000, src2=32'h00FF00FF, ctrl=4'b0001 -> rsp_valid at T+4, result=32'hFFFF00FF. alu_*_o stable from T+1 through T+3.
- Backpressure: rsp_ready_i low for 3 cycles after rsp_valid -> response held stable and both ready outputs low. The next request is accepted on the cycle after rsp_ready_i rises and the response handshake completes.
- Assert rst_i during EXEC -> rsp_valid never rises, all outputs take reset values asynchronously, and the next req0 operation after reset completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared 32-bit ALU: grant, hold operands ALU_LAT cycles, return result.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    input  logic [3:0]  req0_ctrl_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    input  logic [3:0]  req1_ctrl_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);

    state_t      r_state;
    logic [1:0]  r_lat_cnt;
    logic        r_last_id;
    logic        r_id;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [3:0]  r_ctrl;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_idle;

    // Requests are accepted only in IDLE, in any cycle where valid && ready.
    always_comb begin
        w_grant1 = 1'b0;
`ifdef ALU_ARB_RR_EN
        w_grant1 = req1_valid_i && (!req0_valid_i || (r_last_id == 1'b0));
`else
        w_grant1 = req1_valid_i && !req0_valid_i;
`endif
        w_grant0 = req0_valid_i && !w_grant1;
    end

    assign w_idle       = (r_state == IDLE);
    assign req0_ready_o = w_idle && w_grant0;
    assign req1_ready_o = w_idle && w_grant1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_lat_cnt    <= 2'd0;
            r_last_id    <= 1'b1;
            r_id         <= 1'b0;
            r_src1       <= 32'h0;
            r_src2       <= 32'h0;
            r_ctrl       <= 4'h0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'h0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_src1    <= w_grant1 ? req1_src1_i : req0_src1_i;
                        r_src2    <= w_grant1 ? req1_src2_i : req0_src2_i;
                        r_ctrl    <= w_grant1 ? req1_ctrl_i : req0_ctrl_i;
                        r_id      <= w_grant1;
                        r_last_id <= w_grant1;
                        r_lat_cnt <= 2'd0;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (r_lat_cnt == LAT_LAST) begin
                        r_rsp_result <= alu_result_i;
                        r_rsp_zero   <= (alu_result_i == 32'h0);
                        r_rsp_id     <= r_id;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_src1_o   = r_src1;
    assign alu_src2_o   = r_src2;
    assign alu_ctrl_o   = r_ctrl;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_result_o = r_rsp_result;
    assign rsp_zero_o   = r_rsp_zero;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized scoreboard run on an ALU_LAT=1 instance, directed latency/reset runs on ALU_LAT=3.
module tb_alu_arbiter;

    localparam int LAT_A = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A (ALU_LAT=1) ----------------
    logic        rst_a;
    logic        a_v0, a_v1, a_r0, a_r1;
    logic [31:0] a_s1_0, a_s2_0, a_s1_1, a_s2_1;
    logic [3:0]  a_c0, a_c1;
    logic [31:0] a_alu_s1, a_alu_s2, a_alu_res;
    logic [3:0]  a_alu_c;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_id, a_rsp_zero;
    logic [31:0] a_rsp_result;
    logic [1:0]  a_dbg;

    // ---------------- instance B (ALU_LAT=3) ----------------
    logic        rst_b;
    logic        b_v0, b_r0, b_r1;
    logic [31:0] b_s1, b_s2;
    logic [3:0]  b_c;
    logic [31:0] b_alu_s1, b_alu_s2, b_alu_res;
    logic [3:0]  b_alu_c;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero;
    logic [31:0] b_rsp_result;
    logic [1:0]  b_dbg;
    logic        b_v1;
    logic [31:0] b_zero32;
    logic [3:0]  b_zero4;

    // Behavioural ALU sitting behind the arbiter; undecoded codes give 0.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            default: return 32'h0;
        endcase
    endfunction

    assign a_alu_res = alu_f(a_alu_c, a_alu_s1, a_alu_s2);
    assign b_alu_res = alu_f(b_alu_c, b_alu_s1, b_alu_s2);

    alu_arbiter #(.ALU_LAT(LAT_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a),
        .req0_valid_i(a_v0), .req0_ready_o(a_r0),
        .req0_src1_i(a_s1_0), .req0_src2_i(a_s2_0), .req0_ctrl_i(a_c0),
        .req1_valid_i(a_v1), .req1_ready_o(a_r1),
        .req1_src1_i(a_s1_1), .req1_src2_i(a_s2_1), .req1_ctrl_i(a_c1),
        .alu_src1_o(a_alu_s1), .alu_src2_o(a_alu_s2), .alu_ctrl_o(a_alu_c),
        .alu_result_i(a_alu_res),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_id_o(a_rsp_id),
        .rsp_result_o(a_rsp_result), .rsp_zero_o(a_rsp_zero), .dbg_state_o(a_dbg)
    );

    alu_arbiter #(.ALU_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b),
        .req0_valid_i(b_v0), .req0_ready_o(b_r0),
        .req0_src1_i(b_s1), .req0_src2_i(b_s2), .req0_ctrl_i(b_c),
        .req1_valid_i(b_v1), .req1_ready_o(b_r1),
        .req1_src1_i(b_zero32), .req1_src2_i(b_zero32), .req1_ctrl_i(b_zero4),
        .alu_src1_o(b_alu_s1), .alu_src2_o(b_alu_s2), .alu_ctrl_o(b_alu_c),
        .alu_result_i(b_alu_res),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_id_o(b_rsp_id),
        .rsp_result_o(b_rsp_result), .rsp_zero_o(b_rsp_zero), .dbg_state_o(b_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard feed (instance A) ----------------
    logic [32:0] exp_q[$];   // {id, result}
    int  cyc = 0;
    bit  m_busy = 0;
    int  m_acc_cyc = 0;
    bit  m_last_id = 1;

    always @(negedge clk) begin
        bit g0, g1, exp_v;
        if (rst_a) begin
            m_busy    = 0;
            m_last_id = 1;
            exp_q.delete();
        end else begin
            cyc++;
            g0 = 0;
            g1 = 0;
            if (a_v0 && a_v1) begin
`ifdef ALU_ARB_RR_EN
                g1 = (m_last_id == 1'b0);
`else
                g1 = 0;
`endif
                g0 = !g1;
            end else begin
                g0 = a_v0;
                g1 = a_v1;
            end
            exp_v = m_busy && (cyc >= m_acc_cyc + LAT_A + 1);
            chk("req0_ready", {31'b0, a_r0}, {31'b0, !m_busy && g0});
            chk("req1_ready", {31'b0, a_r1}, {31'b0, !m_busy && g1});
            chk("rsp_valid_timing", {31'b0, a_rsp_valid}, {31'b0, exp_v});
            if (!m_busy && (g0 || g1)) begin
                if (g1) exp_q.push_back({1'b1, alu_f(a_c1, a_s1_1, a_s2_1)});
                else    exp_q.push_back({1'b0, alu_f(a_c0, a_s1_0, a_s2_0)});
                m_busy    = 1;
                m_acc_cyc = cyc;
                m_last_id = g1;
            end else if (exp_v && a_rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    // ---------------- monitor (instance A) ----------------
    bit          h_active = 0;
    logic        h_id;
    logic [31:0] h_res;
    logic        h_zero;

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_a) begin
            h_active = 0;
        end else if (a_rsp_valid) begin
            if (h_active) begin
                chk("held_id", {31'b0, a_rsp_id}, {31'b0, h_id});
                chk("held_result", a_rsp_result, h_res);
                chk("held_zero", {31'b0, a_rsp_zero}, {31'b0, h_zero});
            end
            if (a_rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected: got id %0d result %h expected no response", a_rsp_id, a_rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", {31'b0, a_rsp_id}, {31'b0, e[32]});
                    chk("rsp_result", a_rsp_result, e[31:0]);
                    chk("rsp_zero", {31'b0, a_rsp_zero}, {31'b0, e[31:0] == 32'h0});
                end
                h_active = 0;
            end else begin
                h_active = 1;
                h_id     = a_rsp_id;
                h_res    = a_rsp_result;
                h_zero   = a_rsp_zero;
            end
        end else begin
            h_active = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_set0(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
        a_v0 = v; a_s1_0 = x; a_s2_0 = y; a_c0 = c;
    endtask

    task automatic a_set1(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
        a_v1 = v; a_s1_1 = x; a_s2_1 = y; a_c1 = c;
    endtask

    task automatic a_random(input int n);
        logic [31:0] x;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            a_set0($urandom_range(0, 2) != 0, x, ($urandom_range(0, 3) == 0) ? x : $urandom,
                   4'($urandom_range(0, 15)));
            x = $urandom;
            a_set1($urandom_range(0, 2) != 0, x, ($urandom_range(0, 3) == 0) ? x : $urandom,
                   4'($urandom_range(0, 15)));
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
    endtask

    // One LAT=3 operation on instance B with full cycle-by-cycle checks.
    task automatic b_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c,
                        input logic [31:0] exp_res);
        b_v0 = 1; b_s1 = x; b_s2 = y; b_c = c; b_rsp_ready = 1;
        @(negedge clk);
        chk("b_accept", {31'b0, b_r0}, 32'd1);
        step(1);
        b_v0 = 0; b_s1 = ~x; b_s2 = ~y; b_c = ~c;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("b_alu_src1", b_alu_s1, x);
            chk("b_alu_src2", b_alu_s2, y);
            chk("b_alu_ctrl", {28'b0, b_alu_c}, {28'b0, c});
            chk("b_rsp_valid_early", {31'b0, b_rsp_valid}, 32'd0);
        end
        @(negedge clk);
        chk("b_rsp_valid", {31'b0, b_rsp_valid}, 32'd1);
        chk("b_rsp_id", {31'b0, b_rsp_id}, 32'd0);
        chk("b_rsp_result", b_rsp_result, exp_res);
        chk("b_rsp_zero", {31'b0, b_rsp_zero}, {31'b0, exp_res == 32'h0});
        step(1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_a = 1; rst_b = 1;
        a_set0(0, 0, 0, 0); a_set1(0, 0, 0, 0); a_rsp_ready = 1;
        b_v0 = 0; b_v1 = 0; b_s1 = 0; b_s2 = 0; b_c = 0; b_rsp_ready = 1;
        b_zero32 = 32'h0; b_zero4 = 4'h0;
        #1;
        chk("rst_alu_src1", a_alu_s1, 32'h0);
        chk("rst_alu_src2", a_alu_s2, 32'h0);
        chk("rst_alu_ctrl", {28'b0, a_alu_c}, 32'h0);
        chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'b0, a_rsp_id}, 32'd0);
        chk("rst_rsp_result", a_rsp_result, 32'h0);
        chk("rst_rsp_zero", {31'b0, a_rsp_zero}, 32'd0);
        a_v0 = 1; a_v1 = 1;
        #1;
        chk("rst_ready0_contested", {31'b0, a_r0}, 32'd1);
        chk("rst_ready1_contested", {31'b0, a_r1}, 32'd0);
        a_v0 = 0; a_v1 = 0;
        #1;
        chk("rst_ready0_idle", {31'b0, a_r0}, 32'd0);
        step(2);
        rst_a = 0; rst_b = 0;
        step(1);

        // Directed single-requester operations
        a_set0(1, 32'd5, 32'd7, 4'b0010); step(1); a_set0(0, 0, 0, 0); step(3);
        a_set1(1, 32'd9, 32'd9, 4'b0110); step(1); a_set1(0, 0, 0, 0); step(3);
        a_set1(1, 32'd9, 32'd9, 4'b1111); step(1); a_set1(0, 0, 0, 0); step(3);

        // Both continuously valid: arbitration order comes from the model
        a_set0(1, 32'd100, 32'd1, 4'b0010);
        a_set1(1, 32'd200, 32'd2, 4'b0010);
        step(4 * (LAT_A + 2));
        a_set0(0, 0, 0, 0); a_set1(0, 0, 0, 0); step(3);

        // Backpressure: response held for 3 cycles, then next request accepted right after
        a_set0(1, 32'h1234, 32'h4321, 4'b0000); a_rsp_ready = 0;
        step(LAT_A + 4);
        a_rsp_ready = 1;
        step(LAT_A + 3);
        a_set0(0, 0, 0, 0); step(3);

        a_random(1500);

        // Reset while a response is stalled
        a_set0(1, 32'd3, 32'd4, 4'b0010); a_set1(0, 0, 0, 0); a_rsp_ready = 0;
        step(1); a_set0(0, 0, 0, 0); step(LAT_A + 3);
        #2 rst_a = 1;
        #1;
        chk("arst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("arst_rsp_result", a_rsp_result, 32'h0);
        chk("arst_alu_src1", a_alu_s1, 32'h0);
        step(2);
        rst_a = 0; a_rsp_ready = 1;
        step(1);
        a_random(500);

        // Drain
        a_set0(0, 0, 0, 0); a_set1(0, 0, 0, 0); a_rsp_ready = 1;
        step(10);
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        // Instance B: ALU_LAT=3 latency, stability and mid-EXEC reset
        b_op(32'hFFFF0000, 32'h00FF00FF, 4'b0001, 32'hFFFF00FF);
        b_op(32'd9, 32'd9, 4'b0110, 32'h0);
        b_v0 = 1; b_s1 = 32'd1; b_s2 = 32'd2; b_c = 4'b0010;
        step(1);
        b_v0 = 0;
        @(negedge clk);
        #1 rst_b = 1;
        #1;
        chk("b_rst_alu_src1", b_alu_s1, 32'h0);
        chk("b_rst_alu_ctrl", {28'b0, b_alu_c}, 32'h0);
        chk("b_rst_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
        chk("b_rst_rsp_result", b_rsp_result, 32'h0);
        step(1);
        rst_b = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b_no_rsp_after_rst", {31'b0, b_rsp_valid}, 32'd0);
        end
        step(1);
        b_op(32'd5, 32'd7, 4'b0010, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
